// File: rtl/dp_ram_sync.sv
// Simple dual-port synchronous RAM with byte-lane strobes, collision mode select,
// optional output register, read-valid pulse and an optional post-reset clear sweep.
module dp_ram_sync #(
   parameter int    DATA_W         = 8,
   parameter int    LANE_W         = 8,
   parameter int    ADDR_W         = 8,
   parameter int    DEPTH          = 256,
   parameter int    COLLISION      = 0,
   parameter int    OUT_REG        = 0,
   parameter string INIT_FILE      = "",
   parameter int    CLEAR_ON_RESET = 0,
   localparam int   NLANES         = DATA_W / LANE_W
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [NLANES-1:0] wstrb,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_L  = DEPTH[ADDR_W:0];
   localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;
   localparam state_t ST_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   logic [DATA_W-1:0] r_mem [DEPTH];

   state_t            r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
   logic              w_clr_we, w_wr_acc, w_rd_acc;
   logic              w_waddr_ok, w_raddr_ok;
   logic [IDX_W-1:0]  w_widx, w_ridx;
   logic [DATA_W-1:0] w_old, w_rd_word;
   logic              r_rvalid1;
   logic [DATA_W-1:0] r_rdata1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RST;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      busy        = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            busy      = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: ;
      endcase
   end

   assign w_waddr_ok = ({1'b0, waddr} < DEPTH_L);
   assign w_raddr_ok = ({1'b0, raddr} < DEPTH_L);
   assign w_widx     = waddr[IDX_W-1:0];
   assign w_ridx     = raddr[IDX_W-1:0];
   // The sweep must not touch memory while reset is held; it starts on the first edge after release.
   assign w_clr_we   = busy && !rst;
   assign w_wr_acc   = we && !busy && w_waddr_ok;
   assign w_rd_acc   = re && !busy;
   assign w_old      = r_mem[w_ridx];

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_acc) begin
         for (int i = 0; i < NLANES; i++) begin
            if (wstrb[i]) r_mem[w_widx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
         end
      end
   end

   // Write-first merges strobed lanes of the in-flight write over the stored word.
   always_comb begin
      w_rd_word = w_old;
      if (COLLISION != 0 && w_wr_acc && waddr == raddr) begin
         for (int i = 0; i < NLANES; i++) begin
            if (wstrb[i]) w_rd_word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
         end
      end
      if (!w_raddr_ok) w_rd_word = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid1 <= 1'b0;
         r_rdata1  <= '0;
      end else begin
         r_rvalid1 <= w_rd_acc;
         if (w_rd_acc) r_rdata1 <= w_rd_word;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic              r_rvalid2;
         logic [DATA_W-1:0] r_rdata2;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_rvalid2 <= 1'b0;
               r_rdata2  <= '0;
            end else begin
               r_rvalid2 <= r_rvalid1;
               r_rdata2  <= r_rdata1;
            end
         end
         assign rvalid = r_rvalid2;
         assign rdata  = r_rdata2;
      end else begin : g_noreg
         assign rvalid = r_rvalid1;
         assign rdata  = r_rdata1;
      end
   endgenerate

endmodule
